// File: rtl/wisc_pkg.sv
// Shared definitions for the hazard controller.
//   REG_W    : register-specifier width (16 architectural registers)
//   ZERO_REG : index of the hard-wired zero register, never a real dependency
//   state_e  : RUN -> DRAIN -> HALTED controller states
package wisc_pkg;
  localparam int REG_W    = 4;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;
endpackage

// File: rtl/hazard_shadow_stage.sv
// One pipeline-register shadow holding {RegWrite, MemRead, Rd}.
//   clk, rst         : clock, async active-high reset
//   bubble_i         : load all-zero instead of the incoming decode
//   rw_i, mr_i, rd_i : incoming RegWrite / MemRead / Rd
//   rw_o, mr_o, rd_o : registered shadow
module hazard_shadow_stage #(
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble_i,
  input  logic             rw_i,
  input  logic             mr_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             rw_o,
  output logic             mr_o,
  output logic [REG_W-1:0] rd_o
);
  logic             rw_q, mr_q;
  logic [REG_W-1:0] rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q <= 1'b0;
      mr_q <= 1'b0;
      rd_q <= '0;
    end else if (bubble_i) begin
      rw_q <= 1'b0;
      mr_q <= 1'b0;
      rd_q <= '0;
    end else begin
      rw_q <= rw_i;
      mr_q <= mr_i;
      rd_q <= rd_i;
    end
  end

  assign rw_o = rw_q;
  assign mr_o = mr_q;
  assign rd_o = rd_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and register-branch stalls, taken
// branch flush, and HLT drain sequencing.
//   clk, rst                 : clock, async active-high reset
//   IFID_Rs/Rt, UsesRs/Rt    : sources read by the instruction in ID
//   IFID_IsStore             : ID instruction is SW (Rt is store data)
//   ID_RegWrite/MemRead/Rd   : destination decode of the ID instruction
//   ID_BranchReg/Taken/Halt  : BR decoded, branch taken, HLT decoded
//   PC_Stall, IFID_Stall     : hold PC / IF-ID
//   IDEX_Bubble              : zero control written into ID/EX
//   IFID_Flush               : squash IF/ID on a taken branch
//   Halted                   : pipeline drained after HLT
module hazard_ctrl #(
  parameter int REG_W     = wisc_pkg::REG_W,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRs,
  input  logic             IFID_UsesRt,
  input  logic             IFID_IsStore,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic [REG_W-1:0] ID_Rd,
  input  logic             ID_BranchReg,
  input  logic             ID_BranchTaken,
  input  logic             ID_Halt,
  output logic             PC_Stall,
  output logic             IFID_Stall,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             Halted
);
  import wisc_pkg::*;

  localparam int CNT_W = $clog2(DRAIN_CYC) + 1;
  localparam logic [REG_W-1:0] RZ = REG_W'(ZERO_REG);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ex_rw, ex_mr, mem_rw, mem_mr;
  logic [REG_W-1:0] ex_rd, mem_rd;
  logic             stall, flush, halted;
  logic             load_use, br_haz, hazard;

  // ID/EX shadow takes the ID decode unless this cycle inserts a bubble.
  hazard_shadow_stage #(.REG_W(REG_W)) u_idex (
    .clk(clk), .rst(rst), .bubble_i(stall),
    .rw_i(ID_RegWrite), .mr_i(ID_MemRead), .rd_i(ID_Rd),
    .rw_o(ex_rw), .mr_o(ex_mr), .rd_o(ex_rd)
  );

  hazard_shadow_stage #(.REG_W(REG_W)) u_exmem (
    .clk(clk), .rst(rst), .bubble_i(1'b0),
    .rw_i(ex_rw), .mr_i(ex_mr), .rd_i(ex_rd),
    .rw_o(mem_rw), .mr_o(mem_mr), .rd_o(mem_rd)
  );

  // SW data (Rt) is excluded: it is forwarded MEM-to-MEM instead.
  assign load_use = ex_mr && (ex_rd != RZ) &&
                    (((ex_rd == IFID_Rs) && IFID_UsesRs) ||
                     ((ex_rd == IFID_Rt) && IFID_UsesRt && !IFID_IsStore));

  // BR resolves in ID, so it must wait for ALU results in EX and loads in MEM.
  assign br_haz = ID_BranchReg && (IFID_Rs != RZ) &&
                  ((ex_rw && (ex_rd == IFID_Rs)) ||
                   (mem_mr && (mem_rd == IFID_Rs)));

  assign hazard = load_use || br_haz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A stalled HLT is simply seen again once the stall clears.
        if (hazard) begin
          stall = 1'b1;
        end else begin
          flush = ID_BranchTaken;
          if (ID_Halt) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYC - 1);
          end
        end
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are forced low while reset is held, whatever the ID inputs do.
  assign PC_Stall    = stall  & ~rst;
  assign IFID_Stall  = stall  & ~rst;
  assign IDEX_Bubble = stall  & ~rst;
  assign IFID_Flush  = flush  & ~rst;
  assign Halted      = halted & ~rst;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
  localparam int RW = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs, rt, rd;
  logic          urs, urt, st, rw, mr, br, tk, hlt;
  logic          pc_stall, ifid_stall, idex_bubble, ifid_flush, halted;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_W(RW), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst),
    .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRs(urs), .IFID_UsesRt(urt),
    .IFID_IsStore(st), .ID_RegWrite(rw), .ID_MemRead(mr), .ID_Rd(rd),
    .ID_BranchReg(br), .ID_BranchTaken(tk), .ID_Halt(hlt),
    .PC_Stall(pc_stall), .IFID_Stall(ifid_stall), .IDEX_Bubble(idex_bubble),
    .IFID_Flush(ifid_flush), .Halted(halted)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct { bit w; bit m; int d; } ins_t;
  ins_t pipe[2];          // [0] = instruction in EX, [1] = instruction in MEM
  int   mode;             // 0 running, 1 draining, 2 halted
  int   drain_left;       // drain cycles still to spend

  function automatic void model_reset();
    pipe[0] = '{0, 0, 0};
    pipe[1] = '{0, 0, 0};
    mode = 0;
    drain_left = 0;
  endfunction

  function automatic bit model_hazard();
    bit lu, bh;
    int s = int'(rs), t = int'(rt);
    lu = pipe[0].m && pipe[0].d != 0 &&
         ((pipe[0].d == s && urs) || (pipe[0].d == t && urt && !st));
    bh = br && s != 0 &&
         ((pipe[0].w && pipe[0].d == s) || (pipe[1].m && pipe[1].d == s));
    return lu || bh;
  endfunction

  function automatic logic [4:0] model_out();
    bit h = model_hazard();
    if (mode == 2) return 5'b11101;
    if (mode == 1) return 5'b11100;
    if (h)         return 5'b11100;
    return {3'b000, tk, 1'b0};
  endfunction

  function automatic void model_step();
    bit h = model_hazard();
    bit stalled = (mode != 0) || h;
    pipe[1] = pipe[0];
    if (stalled) pipe[0] = '{0, 0, 0};
    else         pipe[0] = '{rw, mr, int'(rd)};
    if (mode == 1) begin
      drain_left--;
      if (drain_left == 0) mode = 2;
    end else if (mode == 0 && !h && hlt) begin
      mode = 1;
      drain_left = DC;
    end
  endfunction

  // ---------------- checking helpers ----------------
  function automatic logic [4:0] got();
    return {pc_stall, ifid_stall, idex_bubble, ifid_flush, halted};
  endfunction

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (stall,stall,bubble,flush,halted) t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int s, input int t, input bit us, input bit ut,
                       input bit isst, input bit w, input bit m, input int d,
                       input bit b, input bit k, input bit h);
    rs = RW'(s); rt = RW'(t); urs = us; urt = ut; st = isst;
    rw = w; mr = m; rd = RW'(d); br = b; tk = k; hlt = h;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic cyc(input string nm, input bit use_lit, input logic [4:0] lit);
    @(negedge clk);
    check({nm, "_model"}, got(), model_out());
    if (use_lit) check(nm, got(), lit);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset pulse entirely between two rising edges.
  task automatic rst_pulse(input string nm);
    #1 rst = 1'b1;
    #1 check(nm, got(), 5'b00000);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    drive(3, 3, 1, 1, 0, 1, 1, 3, 1, 1, 1);   // busy inputs must not leak out
    model_reset();
    #12 check("reset_outputs", got(), 5'b00000);
    rst = 1'b0;
    nop();

    // Load-use: LW R3 then ADD reading R3 -> exactly one stall.
    drive(0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0); cyc("lu_lw",     1, 5'b00000);
    drive(3, 1, 1, 1, 0, 1, 0, 4, 0, 0, 0); cyc("lu_stall",  1, 5'b11100);
    cyc("lu_release", 1, 5'b00000);
    nop();                                  cyc("lu_nop",    1, 5'b00000);

    // SW with Rt = loaded reg: forwarded, no stall.
    drive(0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0); cyc("sw_lw",     1, 5'b00000);
    drive(5, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0); cyc("sw_nostall",1, 5'b00000);

    // Load into R0 is never a dependency.
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cyc("r0_lw",     1, 5'b00000);
    drive(0, 2, 1, 1, 0, 1, 0, 5, 0, 0, 0); cyc("r0_nostall",1, 5'b00000);

    // BR after ADD R4: one stall, then taken flush.
    drive(0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0); cyc("br_add",    1, 5'b00000);
    drive(4, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0); cyc("br_stall1", 1, 5'b11100);
    cyc("br_flush1", 1, 5'b00010);
    // BR after LW R4: two stalls, then flush.
    drive(0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0); cyc("brl_lw",    1, 5'b00000);
    drive(4, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0); cyc("brl_stall1",1, 5'b11100);
    cyc("brl_stall2", 1, 5'b11100);
    cyc("brl_flush",  1, 5'b00010);
    nop();                                  cyc("brl_after", 1, 5'b00000);

    // HLT during a load-use stall: drain starts only after the stall.
    drive(0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0); cyc("hs_lw",     1, 5'b00000);
    drive(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1); cyc("hs_stall",  1, 5'b11100);
    cyc("hs_accept", 1, 5'b00000);
    nop();
    cyc("hs_drain1", 1, 5'b11100);
    cyc("hs_drain2", 1, 5'b11100);
    cyc("hs_drain3", 1, 5'b11100);
    cyc("hs_halt1",  1, 5'b11101);
    drive(3, 3, 1, 1, 0, 1, 1, 3, 1, 1, 1);
    cyc("hs_halt2",  1, 5'b11101);
    cyc("hs_halt3",  1, 5'b11101);
    rst_pulse("hs_reset");
    nop();

    // HLT with no hazard, reset in the second drain cycle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("hr_hlt",    1, 5'b00000);
    nop();
    cyc("hr_drain1", 1, 5'b11100);
    #1 check("hr_drain2", got(), 5'b11100);
    tk = 1'b1;
    rst_pulse("hr_rst_mid");
    cyc("hr_run_flush", 1, 5'b00010);       // back in RUN: flush, no stall
    nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("hr_rehlt",  1, 5'b00000);
    nop();
    cyc("hr_redrain", 1, 5'b11100);
    rst_pulse("hr_rst2");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit w = $urandom_range(0, 1);
      drive($urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), w, w && $urandom_range(0, 1),
            $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0));
      cyc("rand", 0, 5'b00000);
      if ((mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        rst_pulse("rand_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
